posit_add_arbiter: RTL and testbench

Shares one Posit_Adder datapath (N=8, ES=3) between two requesters. Round-robin arbitration over valid/ready request ports. Drives the shared adder's operand inputs from registers and captures its decoded outputs (LE, E, R) after a configurable latency. Returns the result on a single tagged response port with backpressure. Sits between operand producers (e.g. an accumulator FSM and a test stimulus engine) and the adder.

---
 rtl/posit_add_arbiter.sv | 128 ++++++++++++
 tb/tb_posit_add_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_arbiter.sv
// rtl/posit_add_arbiter.sv - round-robin arbiter sharing one posit adder between two requesters
// Registers operands into the adder, captures its decoded scale after ADD_LAT cycles, returns a tagged response.
module posit_add_arbiter #(
  parameter int N       = 8,
  parameter int ES      = 3,
  parameter int RS      = $clog2(N),
  parameter int ADD_LAT = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [N-1:0]     Req0_A,
  input  logic [N-1:0]     Req0_B,
  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [N-1:0]     Req1_A,
  input  logic [N-1:0]     Req1_B,
  output logic [N-1:0]     Add_In1,
  output logic [N-1:0]     Add_In2,
  input  logic [ES+RS:0]   Add_LE,
  input  logic [ES-1:0]    Add_E,
  input  logic [RS:0]      Add_R,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic             Rsp_Id,
  output logic [ES+RS:0]   Rsp_LE,
  output logic [ES-1:0]    Rsp_E,
  output logic [RS:0]      Rsp_R,
  output logic             Busy
);

  localparam int CW = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  generate
    if (ADD_LAT < 1) begin : g_lat_check
      $error("posit_add_arbiter: ADD_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            prio;
  logic [CW-1:0]   cnt;
  logic            grant;
  logic            hs;

  // Ready is suppressed during reset so no transfer is ever signalled on a reset edge.
  always_comb begin
    state_nxt  = state;
    grant      = Req1_Valid;
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    if (Req0_Valid && Req1_Valid) begin
      grant = prio;
    end
    case (state)
      IDLE: begin
        Req0_Ready = !Reset && Req0_Valid && !grant;
        Req1_Ready = !Reset && Req1_Valid && grant;
        if (Req0_Ready || Req1_Ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (Rsp_Ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hs   = Req0_Ready || Req1_Ready;
  assign Busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cnt       <= '0;
      Add_In1   <= '0;
      Add_In2   <= '0;
      Rsp_Valid <= 1'b0;
      Rsp_Id    <= 1'b0;
      Rsp_LE    <= '0;
      Rsp_E     <= '0;
      Rsp_R     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (hs) begin
            Add_In1 <= grant ? Req1_A : Req0_A;
            Add_In2 <= grant ? Req1_B : Req0_B;
            Rsp_Id  <= grant;
            prio    <= ~grant;
            cnt     <= CW'(ADD_LAT);
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // Adder outputs are only sampled on the final countdown edge.
          if (cnt == CW'(1)) begin
            Rsp_LE    <= Add_LE;
            Rsp_E     <= Add_E;
            Rsp_R     <= Add_R;
            Rsp_Valid <= 1'b1;
          end
        end
        RESP: begin
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_add_arbiter.sv
// tb/tb_posit_add_arbiter.sv - self-checking bench for posit_add_arbiter
// Transaction-level model checked every cycle on DUT A (ADD_LAT=1); directed checks on A and on DUT B (ADD_LAT=3).
module tb_posit_add_arbiter;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = 3;
  localparam int LAT_A = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          v0, v1, r0, r1, rsp_valid, rsp_ready, rsp_id, busy;
  logic [N-1:0]  a0, b0, a1, b1, in1, in2;
  logic [ES+RS:0] add_le, rsp_le;
  logic [ES-1:0] add_e, rsp_e;
  logic [RS:0]   add_r, rsp_r;

  logic          v0b, v1b, r0b, r1b, rsp_valid_b, rsp_ready_b, rsp_id_b, busy_b;
  logic [N-1:0]  a0b, b0b, a1b, b1b, in1b, in2b;
  logic [ES+RS:0] add_le_b, rsp_le_b;
  logic [ES-1:0] add_e_b, rsp_e_b;
  logic [RS:0]   add_r_b, rsp_r_b;

  posit_add_arbiter #(.N(N), .ES(ES), .RS(RS), .ADD_LAT(LAT_A)) dut_a (
    .Clock(clk), .Reset(rst),
    .Req0_Valid(v0), .Req0_Ready(r0), .Req0_A(a0), .Req0_B(b0),
    .Req1_Valid(v1), .Req1_Ready(r1), .Req1_A(a1), .Req1_B(b1),
    .Add_In1(in1), .Add_In2(in2), .Add_LE(add_le), .Add_E(add_e), .Add_R(add_r),
    .Rsp_Valid(rsp_valid), .Rsp_Ready(rsp_ready), .Rsp_Id(rsp_id),
    .Rsp_LE(rsp_le), .Rsp_E(rsp_e), .Rsp_R(rsp_r), .Busy(busy)
  );

  posit_add_arbiter #(.N(N), .ES(ES), .RS(RS), .ADD_LAT(3)) dut_b (
    .Clock(clk), .Reset(rst),
    .Req0_Valid(v0b), .Req0_Ready(r0b), .Req0_A(a0b), .Req0_B(b0b),
    .Req1_Valid(v1b), .Req1_Ready(r1b), .Req1_A(a1b), .Req1_B(b1b),
    .Add_In1(in1b), .Add_In2(in2b), .Add_LE(add_le_b), .Add_E(add_e_b), .Add_R(add_r_b),
    .Rsp_Valid(rsp_valid_b), .Rsp_Ready(rsp_ready_b), .Rsp_Id(rsp_id_b),
    .Rsp_LE(rsp_le_b), .Rsp_E(rsp_e_b), .Rsp_R(rsp_r_b), .Busy(busy_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one op in flight at a time; a response waits LAT_A edges after its grant, then until consumed.
  bit             m_pend = 0, m_rv = 0, m_prio = 0, m_id = 0;
  int             m_left = 0;
  logic [N-1:0]   m_in1 = '0, m_in2 = '0;
  logic [ES+RS:0] m_le = '0;
  logic [ES-1:0]  m_e = '0;
  logic [RS:0]    m_r = '0;
  bit             g1, er0, er1;

  always @(negedge clk) begin
    g1  = (v0 && v1) ? m_prio : v1;
    er0 = !rst && !m_pend && !m_rv && v0 && !g1;
    er1 = !rst && !m_pend && !m_rv && v1 && g1;
    chk("m_ready0", 32'(r0), 32'(er0));
    chk("m_ready1", 32'(r1), 32'(er1));
    chk("m_busy", 32'(busy), 32'(m_pend || m_rv));
    chk("m_add_in1", 32'(in1), 32'(m_in1));
    chk("m_add_in2", 32'(in2), 32'(m_in2));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
    chk("m_rsp_le", 32'(rsp_le), 32'(m_le));
    chk("m_rsp_e", 32'(rsp_e), 32'(m_e));
    chk("m_rsp_r", 32'(rsp_r), 32'(m_r));
    if (rst) begin
      m_pend = 0; m_rv = 0; m_prio = 0; m_id = 0; m_left = 0;
      m_in1 = '0; m_in2 = '0; m_le = '0; m_e = '0; m_r = '0;
    end else if (er0 || er1) begin
      m_id   = er1;
      m_in1  = er1 ? a1 : a0;
      m_in2  = er1 ? b1 : b0;
      m_prio = !er1;
      m_left = LAT_A;
      m_pend = 1;
    end else if (m_pend) begin
      m_left--;
      if (m_left == 0) begin
        m_pend = 0; m_rv = 1;
        m_le = add_le; m_e = add_e; m_r = add_r;
      end
    end else if (m_rv && rsp_ready) begin
      m_rv = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int hs_id[$];
  int hs_cyc[$];

  initial begin
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b0;
    a0 = 8'h21; b0 = 8'h14; a1 = 8'hE1; b1 = 8'h33;
    add_le = 7'h05; add_e = 3'b010; add_r = 4'hF;
    v0b = 1'b0; v1b = 1'b0; rsp_ready_b = 1'b0;
    a0b = 8'h4E; b0b = 8'h21; a1b = 8'h00; b1b = 8'h00;
    add_le_b = 7'h11; add_e_b = 3'd1; add_r_b = 4'd1;

    // Reset with both requesters valid
    step(); step();
    chk("rst_add_in1", 32'(in1), 32'h0);
    chk("rst_add_in2", 32'(in2), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready0", 32'(r0), 32'h0);
    chk("rst_busy_b", 32'(busy_b), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(r0), 32'h1);
    chk("post_rst_ready1", 32'(r1), 32'h0);

    // Req0 transfer, ADD_LAT=1
    step();
    v0 = 1'b0;
    chk("t2_add_in1", 32'(in1), 32'h21);
    chk("t2_add_in2", 32'(in2), 32'h14);
    chk("t2_busy", 32'(busy), 32'h1);
    chk("t2_rsp_valid_early", 32'(rsp_valid), 32'h0);
    step();
    chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t2_rsp_id", 32'(rsp_id), 32'h0);
    chk("t2_rsp_le", 32'(rsp_le), 32'h05);
    chk("t2_rsp_e", 32'(rsp_e), 32'h2);
    chk("t2_rsp_r", 32'(rsp_r), 32'hF);

    // Backpressure while the stub keeps changing
    for (int i = 0; i < 5; i++) begin
      add_le = 7'(8'h10 + i); add_e = 3'(i); add_r = 4'(i);
      step();
      chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t4_rsp_le", 32'(rsp_le), 32'h05);
      chk("t4_rsp_e", 32'(rsp_e), 32'h2);
      chk("t4_rsp_r", 32'(rsp_r), 32'hF);
      chk("t4_ready1", 32'(r1), 32'h0);
      chk("t4_busy", 32'(busy), 32'h1);
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_rsp_drop", 32'(rsp_valid), 32'h0);
    chk("t4_ready1_rise", 32'(r1), 32'h1);
    rsp_ready = 1'b0;

    // Reset during a Req1 op in WAIT
    step();
    chk("t5_add_in1", 32'(in1), 32'hE1);
    chk("t5_busy", 32'(busy), 32'h1);
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
    step();
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t5_busy_clr", 32'(busy), 32'h0);
    rst = 1'b0;
    #1;
    chk("t5_ready0", 32'(r0), 32'h1);
    chk("t5_ready1", 32'(r1), 32'h0);

    // Both valid continuously: alternating grants every 3 cycles
    a0 = 8'h4E; a1 = 8'hE1; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (r0) begin hs_id.push_back(0); hs_cyc.push_back(c); end
      if (r1) begin hs_id.push_back(1); hs_cyc.push_back(c); end
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("t3_count", 32'(hs_id.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_id.size()) begin
        chk("t3_grant_id", 32'(hs_id[i]), 32'(i % 2));
        chk("t3_grant_cycle", 32'(hs_cyc[i]), 32'(3 * i));
      end
    end

    // ADD_LAT=3 instance: only the value present before the third edge is captured
    v0b = 1'b1;
    #1;
    chk("t6_ready0", 32'(r0b), 32'h1);
    step();
    v0b = 1'b0;
    chk("t6_add_in1", 32'(in1b), 32'h4E);
    chk("t6_add_in2", 32'(in2b), 32'h21);
    chk("t6_rv_h0", 32'(rsp_valid_b), 32'h0);
    add_le_b = 7'h22; add_e_b = 3'd3; add_r_b = 4'd2;
    step();
    chk("t6_rv_h1", 32'(rsp_valid_b), 32'h0);
    add_le_b = 7'h33; add_e_b = 3'd4; add_r_b = 4'd3;
    step();
    chk("t6_rv_h2", 32'(rsp_valid_b), 32'h0);
    add_le_b = 7'h4A; add_e_b = 3'b101; add_r_b = 4'h9;
    step();
    chk("t6_rv_h3", 32'(rsp_valid_b), 32'h1);
    chk("t6_rsp_le", 32'(rsp_le_b), 32'h4A);
    chk("t6_rsp_e", 32'(rsp_e_b), 32'h5);
    chk("t6_rsp_r", 32'(rsp_r_b), 32'h9);
    chk("t6_rsp_id", 32'(rsp_id_b), 32'h0);
    add_le_b = 7'h00;
    rsp_ready_b = 1'b1;
    step();
    chk("t6_rv_done", 32'(rsp_valid_b), 32'h0);
    chk("t6_busy_done", 32'(busy_b), 32'h0);
    chk("t6_le_held", 32'(rsp_le_b), 32'h4A);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
